// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package fifo_pkg;

  // Default almost-empty level and distance of almost-full from DEPTH.
  localparam int AE_LVL_DEF = 2;
  localparam int AF_OFS_DEF = 2;

  // Smallest r with (1 << r) >= n; used for address and count widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // True when n is a positive power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: WIDTH x DEPTH array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is allowed. Contents are never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             ck,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the write word; storage is deliberately left out of reset.
  always_ff @(posedge ck) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_p.sv
// Synchronous FIFO with registered flags, count, sticky overflow/underflow and optional FWFT.
// Latency: FWFT=0 data one edge after an accepted Ren; FWFT=1 head word shown once Fempty drops.
// Backpressure: writes rejected while full unless a read is accepted in the same cycle (Ovf sticks).
module sync_fifo_p
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - AF_OFS_DEF,
  parameter int AE_LVL = AE_LVL_DEF,
  parameter int FWFT   = 0
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      Din,
  input  logic                  Wen,
  input  logic                  Ren,
  output logic [WIDTH-1:0]      Dout,
  output logic                  Fempty,
  output logic                  Ffull,
  output logic                  Falmost,
  output logic                  Ealmost,
  output logic [clog2(DEPTH):0] Count,
  output logic                  Ovf,
  output logic                  Udf
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds sized to the count so comparisons stay width-matched.
  localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LVL);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Parameter sanity: reject illegal geometries at elaboration time.
  if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
    $error("sync_fifo_p: DEPTH must be a power of two in 4..1024");
  end
  if (AE_LVL >= AF_LVL) begin : g_bad_levels
    $error("sync_fifo_p: AE_LVL must be below AF_LVL");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sync_fifo_p: WIDTH must be in 1..64");
  end

  // Pointers carry an extra wrap bit above the address bits.
  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_q, empty_d;
  logic full_q,  full_d;
  logic af_q,    af_d;
  logic ae_q,    ae_d;
  logic ovf_q,   ovf_d;
  logic udf_q,   udf_d;

  logic             rd_acc;
  logic             wr_acc;
  logic             mem_we;
  logic [WIDTH-1:0] rd_dat;

  // Handshake decode: a read needs a stored word; a write needs room or a same-cycle read.
  always_comb begin
    rd_acc = Ren && !empty_q;
    wr_acc = Wen && (!full_q || rd_acc);
    mem_we = wr_acc && rst;
  end

  // Next-state for pointers, count, flags and sticky errors, all derived from registered state.
  always_comb begin
    wptr_d  = wr_acc ? (wptr_q + ONE) : wptr_q;
    rptr_d  = rd_acc ? (rptr_q + ONE) : rptr_q;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    // Full: same address, opposite lap. Empty: identical pointers.
    full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    empty_d = (wptr_d == rptr_d);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    ovf_d   = ovf_q || (Wen && !wr_acc);
    udf_d   = udf_q || (Ren && empty_q);
  end

  // Control state register; reset overrides any request in the same cycle.
  always_ff @(posedge ck) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .ck      (ck),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (Din),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rd_dat)
  );

  if (FWFT == 0) begin : g_reg_out
    logic [WIDTH-1:0] dout_q;

    // Registered read: capture the head word on the edge that pops it, hold otherwise.
    always_ff @(posedge ck) begin
      if (!rst)        dout_q <= '0;
      else if (rd_acc) dout_q <= rd_dat;
    end

    assign Dout = dout_q;
  end else begin : g_fwft
    // Head word falls straight through; forced to zero while nothing is readable.
    assign Dout = empty_q ? '0 : rd_dat;
  end

  assign Fempty  = empty_q;
  assign Ffull   = full_q;
  assign Falmost = af_q;
  assign Ealmost = ae_q;
  assign Count   = count_q;
  assign Ovf     = ovf_q;
  assign Udf     = udf_q;

endmodule

// File: tb/tb_sync_fifo_p.sv
// Bench for sync_fifo_p: a registered-read instance and an FWFT instance share one stimulus stream.
// Latency: expected words queued when a read is issued, popped by a monitor when the DUT shows them.
// Backpressure: reference model applies the accept rules with plain queues.
module tb_sync_fifo_p;

  localparam int DA  = 16;
  localparam int AFA = 14;
  localparam int AEA = 2;
  localparam int DB  = 8;
  localparam int AFB = 6;
  localparam int AEB = 2;

  logic       ck = 1'b0;
  logic       rst, wen, ren;
  logic [7:0] din;

  logic [7:0] a_dout, b_dout;
  logic       a_empty, a_full, a_af, a_ae, a_ovf, a_udf;
  logic       b_empty, b_full, b_af, b_ae, b_ovf, b_udf;
  logic [4:0] a_count;
  logic [3:0] b_count;

  always #5 ck = ~ck;

  sync_fifo_p #(.WIDTH(8), .DEPTH(DA), .AF_LVL(AFA), .AE_LVL(AEA), .FWFT(0)) u_a (
    .ck(ck), .rst(rst), .Din(din), .Wen(wen), .Ren(ren), .Dout(a_dout),
    .Fempty(a_empty), .Ffull(a_full), .Falmost(a_af), .Ealmost(a_ae),
    .Count(a_count), .Ovf(a_ovf), .Udf(a_udf)
  );

  sync_fifo_p #(.WIDTH(8), .DEPTH(DB), .AF_LVL(AFB), .AE_LVL(AEB), .FWFT(1)) u_b (
    .ck(ck), .rst(rst), .Din(din), .Wen(wen), .Ren(ren), .Dout(b_dout),
    .Fempty(b_empty), .Ffull(b_full), .Falmost(b_af), .Ealmost(b_ae),
    .Count(b_count), .Ovf(b_ovf), .Udf(b_udf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: stored words per instance, sticky flags, registered Dout of instance A.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  bit         m_ovf [2];
  bit         m_udf [2];
  logic [7:0] m_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int msz(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_step(input int k, input logic r, input logic w, input logic rd,
                            input logic [7:0] d);
    int dep, sz;
    bit racc, wacc;
    logic [7:0] v;
    dep = (k == 0) ? DA : DB;
    if (!r) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      m_ovf[k] = 1'b0;
      m_udf[k] = 1'b0;
      if (k == 0) m_dout = 8'h00;
    end else begin
      sz   = msz(k);
      racc = rd && (sz > 0);
      wacc = w && ((sz < dep) || racc);
      if (rd && sz == 0) m_udf[k] = 1'b1;
      if (w && !wacc)    m_ovf[k] = 1'b1;
      if (racc) begin
        if (k == 0) begin v = mq0.pop_front(); exp0.push_back(v); m_dout = v; end
        else        begin v = mq1.pop_front(); exp1.push_back(v); end
      end
      if (wacc) begin
        if (k == 0) mq0.push_back(d); else mq1.push_back(d);
      end
    end
  endtask

  task automatic check_state(input int k);
    int sz;
    sz = msz(k);
    if (k == 0) begin
      chk("a_count",   32'(a_count), 32'(sz));
      chk("a_empty",   32'(a_empty), 32'(sz == 0));
      chk("a_full",    32'(a_full),  32'(sz == DA));
      chk("a_falmost", 32'(a_af),    32'(sz >= AFA));
      chk("a_ealmost", 32'(a_ae),    32'(sz <= AEA));
      chk("a_ovf",     32'(a_ovf),   32'(m_ovf[0]));
      chk("a_udf",     32'(a_udf),   32'(m_udf[0]));
      chk("a_dout",    32'(a_dout),  32'(m_dout));
    end else begin
      chk("b_count",   32'(b_count), 32'(sz));
      chk("b_empty",   32'(b_empty), 32'(sz == 0));
      chk("b_full",    32'(b_full),  32'(sz == DB));
      chk("b_falmost", 32'(b_af),    32'(sz >= AFB));
      chk("b_ealmost", 32'(b_ae),    32'(sz <= AEB));
      chk("b_ovf",     32'(b_ovf),   32'(m_ovf[1]));
      chk("b_udf",     32'(b_udf),   32'(m_udf[1]));
    end
  endtask

  // One clock of stimulus: compare current state, drive, advance the model, step past the edge.
  task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
    check_state(0);
    check_state(1);
    rst = r; wen = w; ren = rd; din = d;
    model_step(0, r, w, rd, d);
    model_step(1, r, w, rd, d);
    @(posedge ck);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a DUT read handshake completes.
  initial begin
    bit         pend_a;
    logic [7:0] e;
    pend_a = 1'b0;
    forever begin
      @(negedge ck);
      if (pend_a) begin
        if (exp0.size() == 0) begin
          n_checks++;
          $display("FAIL a_rd_data: got %0h expected nothing (no queued word)", a_dout);
        end else begin
          e = exp0.pop_front();
          chk("a_rd_data", 32'(a_dout), 32'(e));
        end
      end
      pend_a = (rst === 1'b1) && (ren === 1'b1) && (a_empty === 1'b0);
      if ((rst === 1'b1) && (ren === 1'b1) && (b_empty === 1'b0)) begin
        if (exp1.size() == 0) begin
          n_checks++;
          $display("FAIL b_rd_data: got %0h expected nothing (no queued word)", b_dout);
        end else begin
          e = exp1.pop_front();
          chk("b_rd_data", 32'(b_dout), 32'(e));
        end
      end
    end
  end

  initial begin
    logic r, w, rd;
    int   wp;
    rst = 1'b0; wen = 1'b0; ren = 1'b0; din = 8'h00;
    model_step(0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_step(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge ck);
    #1;
    chk("rst_a_empty",   32'(a_empty), 1);
    chk("rst_a_ealmost", 32'(a_ae),    1);
    chk("rst_a_count",   32'(a_count), 0);
    chk("rst_a_dout",    32'(a_dout),  0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // Fill to full, overflow once, then drain in order.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i));
    chk("a_full_16",  32'(a_full),  1);
    chk("a_count_16", 32'(a_count), 16);
    chk("a_ovf_pre",  32'(a_ovf),   0);
    cyc(1'b1, 1'b1, 1'b0, 8'h11);
    chk("a_ovf_17",   32'(a_ovf),   1);
    chk("a_count_17", 32'(a_count), 16);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("a_empty_drained", 32'(a_empty), 1);

    // Simultaneous write and read while full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b1, 1'b1, 8'hAA);
    chk("a_full_both_cnt",  32'(a_count), 16);
    chk("a_full_both_full", 32'(a_full),  1);
    chk("a_full_both_dout", 32'(a_dout),  'h20);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("a_last_aa", 32'(a_dout), 'hAA);

    // Simultaneous write and read while empty.
    chk("a_udf_pre", 32'(a_udf), 0);
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    chk("a_empty_both_udf",  32'(a_udf),   1);
    chk("a_empty_both_cnt",  32'(a_count), 1);
    chk("a_empty_both_dout", 32'(a_dout),  'hAA);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("a_read_55", 32'(a_dout), 'h55);

    // Interleaved write/read long enough to wrap both pointers twice.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'($urandom));
      chk("a_wrap_cnt1", 32'(a_count), 1);
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk("a_wrap_cnt0", 32'(a_count), 0);
    end

    // FWFT single-word fall-through.
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h3C);
    chk("b_fwft_empty", 32'(b_empty), 0);
    chk("b_fwft_dout",  32'(b_dout),  'h3C);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("b_fwft_pop_empty", 32'(b_empty), 1);

    // Thresholds, mid-stream reset with Wen, first write after reset lands at address 0.
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
    chk("b_af_at5", 32'(b_af), 0);
    cyc(1'b1, 1'b1, 1'b0, 8'h66);
    chk("b_af_at6",  32'(b_af),    1);
    chk("b_cnt_at6", 32'(b_count), 6);
    cyc(1'b0, 1'b1, 1'b0, 8'h77);
    chk("b_rst_af",    32'(b_af),    0);
    chk("b_rst_ae",    32'(b_ae),    1);
    chk("b_rst_empty", 32'(b_empty), 1);
    chk("b_rst_count", 32'(b_count), 0);
    cyc(1'b1, 1'b1, 1'b0, 8'h5A);
    chk("b_addr0", 32'(u_b.u_mem.mem_q[0]), 'h5A);
    chk("b_post_rst_dout", 32'(b_dout), 'h5A);

    // Randomized traffic with alternating fill/drain bias and rare resets.
    for (int i = 0; i < 1500; i++) begin
      wp = ((i / 250) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      cyc(r, w, rd, 8'($urandom));
    end

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("a_sb_drained", 32'(exp0.size()), 0);
    chk("b_sb_drained", 32'(exp1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_p.md
SYNC_FIFO_P -- requirements
Module: sync_fifo_p

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 16, entry count, power of two, 4..1024.
REQ-003 SHALL provide parameter AF_LVL, default DEPTH-2, Falmost asserts when count >= AF_LVL.
REQ-004 SHALL provide parameter AE_LVL, default 2, Ealmost asserts when count <= AE_LVL.
REQ-005 SHALL provide parameter FWFT, default 0, where 0 = registered read and 1 = first-word-fall-through.
REQ-006 SHALL provide port ck, input, 1, clock; all state updates on the rising edge.
REQ-007 SHALL provide port rst, input, 1, reset, synchronous, active-low.
REQ-008 SHALL provide port Din, input, WIDTH, write data.
REQ-009 SHALL provide port Wen, input, 1, write request.
REQ-010 SHALL provide port Ren, input, 1, read request (FWFT=1: acknowledge of the head word).
REQ-011 SHALL provide port Dout, output, WIDTH, read data.
REQ-012 SHALL provide port Fempty, output, 1, no readable word.
REQ-013 SHALL provide port Ffull, output, 1, DEPTH words stored.
REQ-014 SHALL provide port Falmost, output, 1, almost full.
REQ-015 SHALL provide port Ealmost, output, 1, almost empty.
REQ-016 SHALL provide port Count, output, CW = log2(DEPTH)+1, stored word count 0..DEPTH.
REQ-017 SHALL provide port Ovf, output, 1, sticky flag for a write attempted while full and not accepted.
REQ-018 SHALL provide port Udf, output, 1, sticky flag for a read attempted while empty.

Function
REQ-019 Write pointer and read pointer SHALL each be log2(DEPTH)+1 bits, with the MSB as the wrap bit; address = low bits; wrap is modulo DEPTH with no special case.
REQ-020 Full SHALL be defined as equal addresses with differing wrap bits; empty SHALL be defined as equal pointers.
REQ-021 A write SHALL be accepted when Wen=1 and (Ffull=0 or an accepted read occurs in the same cycle); on acceptance, mem[waddr] <= Din and the write pointer increments.
REQ-022 A read SHALL be accepted when Ren=1 and Fempty=0; the read pointer increments.
REQ-023 Simultaneous write and read accepted while full SHALL leave Count unchanged, keep Ffull=1, and store Din into the freed slot.
REQ-024 Simultaneous Wen and Ren while empty SHALL accept the write only, ignore the read, set Udf, and leave Dout unchanged (FWFT=0).
REQ-025 Count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-026 Ffull, Fempty, Falmost and Ealmost SHALL be registered and reflect the Count value of the same cycle, with no combinational path from Wen/Ren to any flag.
REQ-027 FWFT=0: Dout SHALL load mem[raddr] on the edge that accepts a read (1-cycle latency) and hold otherwise.
REQ-028 FWFT=0: Fempty SHALL deassert on the edge following the first accepted write into an empty FIFO.
REQ-029 FWFT=1: Dout SHALL present the head word whenever Fempty=0, and Ren SHALL pop it.
REQ-030 FWFT=1: Fempty SHALL deassert 1 cycle after the write into an empty FIFO, with Dout valid in that same cycle.
REQ-031 FWFT=1: Dout SHALL be don't-care while Fempty=1.
REQ-032 Ovf SHALL be set by a rejected write, Udf SHALL be set by Ren=1 while Fempty=1, and both SHALL clear only on reset.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-034 When rst=0 at a rising edge, the block SHALL set pointers=0, Count=0, Fempty=1, Ffull=0, Falmost=0, Ealmost=1, Ovf=0, Udf=0 and Dout=0.
REQ-035 Reset SHALL override Wen and Ren in the same cycle; an asserted reset mid-stream SHALL discard all stored words, with the first post-reset write landing at address 0.

Structure
REQ-036 A shared package fifo_pkg SHALL hold the clog2 helper constant function and the default-level constants (AE default 2, AF offset 2).
REQ-037 Storage SHALL be one sub-module, fifo_mem: a WIDTH x DEPTH array with 1 synchronous write port and 1 asynchronous read port, and no reset.
REQ-038 Pointer, count, flag and output logic SHALL reside in sync_fifo_p.
REQ-039 Elaboration SHALL fail if DEPTH is not a power of two or if AE_LVL >= AF_LVL.

Verification
REQ-040 Defaults, FWFT=0: write 0x01..0x10 -> Ffull=1 after the 16th edge and Count=16; a 17th write -> Ovf=1 and Count stays 16; 16 reads return 0x01..0x10 in order, 1 cycle after each Ren; after the last read, Fempty=1.
REQ-041 Full, with Wen=Ren=1 and Din=0xAA -> Count=16, Ffull=1, Dout=oldest word; after draining, 0xAA emerges last.
REQ-042 Empty, with Wen=Ren=1 and Din=0x55 -> Udf=1, Count=1, Dout unchanged; the next read returns 0x55.
REQ-043 Wrap: 40 cycles of interleaved single write then read -> pointers wrap twice, all data matches, Count toggles between 0 and 1.
REQ-044 FWFT=1, DEPTH=8: single write of 0x3C to an empty FIFO -> next cycle Fempty=0 and Dout=0x3C; Ren=1 -> following cycle Fempty=1.
REQ-045 Thresholds and reset: AF_LVL=6 and AE_LVL=2; with 6 words, assert rst=0 for 1 cycle with Wen=1 -> Falmost: 1 at count 6, 0 after reset; Ealmost=1, Fempty=1, Count=0; the next write lands at address 0.
